// File: rtl/fruit_pkg.sv
// Shared types, screen constants and helpers for the fruit spawn controller.
package fruit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_PAUSED    = 2'd3
  } ctrl_state_t;

  localparam int SLOT_CNT  = 4;
  localparam int SCR_X_MAX = 639;
  localparam int SCR_Y_MAX = 479;

  typedef logic signed [7:0]  vel_t;
  typedef logic signed [10:0] spos_t;

  // Horizontal launch speed chosen by two random bits.
  function automatic vel_t launch_vx(input logic [1:0] sel);
    case (sel)
      2'b00:   launch_vx = -8'sd2;
      2'b01:   launch_vx = -8'sd1;
      2'b10:   launch_vx = 8'sd1;
      default: launch_vx = 8'sd2;
    endcase
  endfunction

endpackage

// File: rtl/fruit_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only when enabled.
module fruit_lfsr
  import fruit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [10:0] rnd_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[10:0];

endmodule

// File: rtl/fruit_spawn_ctrl.sv
// Frame-rate scheduler for up to NUM_SLOTS fruits: launch, gravity, bounce,
// slice/miss retirement and the IDLE/COUNTDOWN/RUN/PAUSED game control.
module fruit_spawn_ctrl
  import fruit_pkg::*;
#(
  parameter int          NUM_SLOTS    = SLOT_CNT,
  parameter int          SPAWN_PERIOD = 60,
  parameter int          COUNTDOWN    = 120,
  parameter int          LAUNCH_VY    = 16,
  parameter int          GRAVITY      = 1,
  parameter int          FRUIT_SIZE   = 24,
  parameter int          Y_MAX        = SCR_Y_MAX,
  parameter int          X_MAX        = SCR_X_MAX,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    slice_valid,
  input  logic [1:0]              slice_idx,
  output logic [10*NUM_SLOTS-1:0] FruitX,
  output logic [10*NUM_SLOTS-1:0] FruitY,
  output logic [9:0]              FruitS,
  output logic [NUM_SLOTS-1:0]    fruit_active,
  output logic                    hit_pulse,
  output logic                    miss_pulse,
  output logic                    launch_pulse,
  output logic [1:0]              ctrl_state
);

  ctrl_state_t          state_q, state_d;
  logic [7:0]           cd_q, cd_d, sp_q, sp_d;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           x_d [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           y_d [NUM_SLOTS];
  vel_t                 vx_q [NUM_SLOTS];
  vel_t                 vx_d [NUM_SLOTS];
  vel_t                 vy_q [NUM_SLOTS];
  vel_t                 vy_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic                 hit_q, hit_d, miss_q, miss_d, launch_q, launch_d;
  logic                 lfsr_en_s;
  logic [10:0]          rnd_s;

  fruit_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i (frame_clk),
    .rst_i (Reset),
    .en_i  (lfsr_en_s),
    .rnd_o (rnd_s)
  );

  // Launch eligibility uses act_q, so slots freed this frame wait a frame.
  always_comb begin : next_state_p
    spos_t x_new, y_new;
    logic  sliced, launch_try, placed;
    state_d    = state_q;
    cd_d       = cd_q;
    sp_d       = sp_q;
    x_d        = x_q;
    y_d        = y_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    act_d      = act_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    launch_d   = 1'b0;
    lfsr_en_s  = 1'b0;
    x_new      = 11'sd0;
    y_new      = 11'sd0;
    sliced     = 1'b0;
    launch_try = 1'b0;
    placed     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNTDOWN;
          cd_d    = 8'(COUNTDOWN - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNTDOWN: begin
        if (cd_q == 8'd0) begin
          state_d = ST_RUN;
          sp_d    = 8'd0;
        end else begin
          cd_d = cd_q - 8'd1;
        end
      end
      ST_RUN: begin
        if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          lfsr_en_s  = 1'b1;
          launch_try = (sp_q == 8'd0);
          sp_d       = launch_try ? 8'(SPAWN_PERIOD - 1) : (sp_q - 8'd1);
          for (int i = 0; i < NUM_SLOTS; i++) begin
            sliced = slice_valid && (slice_idx == 2'(i));
            y_new  = spos_t'({1'b0, y_q[i]}) + spos_t'(vy_q[i]);
            x_new  = spos_t'({1'b0, x_q[i]}) + spos_t'(vx_q[i]);
            if (act_q[i]) begin
              y_d[i]  = y_new[9:0];
              vy_d[i] = vy_q[i] + vel_t'(GRAVITY);
              if ((x_new < 11'sd0) || (x_new > spos_t'(X_MAX))) begin
                vx_d[i] = -vx_q[i];
              end else begin
                x_d[i] = x_new[9:0];
              end
              if (sliced) begin
                act_d[i] = 1'b0;
                hit_d    = 1'b1;
              end else if ((vy_q[i] > 8'sd0) && (y_new >= spos_t'(Y_MAX))) begin
                act_d[i] = 1'b0;
                miss_d   = 1'b1;
              end else begin
                act_d[i] = 1'b1;
              end
            end else if (launch_try && !placed) begin
              placed   = 1'b1;
              x_d[i]   = 10'd64 + {1'b0, rnd_s[8:0]};
              y_d[i]   = 10'(Y_MAX);
              vy_d[i]  = -vel_t'(LAUNCH_VY);
              vx_d[i]  = launch_vx(rnd_s[10:9]);
              act_d[i] = 1'b1;
              launch_d = 1'b1;
            end else begin
              act_d[i] = 1'b0;
            end
          end
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cd_q     <= 8'd0;
      sp_q     <= 8'd0;
      x_q      <= '{default: '0};
      y_q      <= '{default: '0};
      vx_q     <= '{default: '0};
      vy_q     <= '{default: '0};
      act_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      sp_q     <= sp_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      act_q    <= act_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      launch_q <= launch_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign FruitX[10*g +: 10] = x_q[g];
    assign FruitY[10*g +: 10] = y_q[g];
  end

  assign FruitS       = 10'(FRUIT_SIZE);
  assign fruit_active = act_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign launch_pulse = launch_q;
  assign ctrl_state   = state_q;

endmodule

// File: tb/tb_fruit_spawn_ctrl.sv
// Directed bench: default-parameter instance for timing, trajectory and pause;
// a fast-spawn instance for slot exhaustion, slice/miss interplay and reset.
module tb_fruit_spawn_ctrl;

  logic frame_clk = 1'b0;
  logic Reset;
  always #5 frame_clk = ~frame_clk;

  logic        a_start, a_pause, a_sv;
  logic [1:0]  a_si;
  logic [39:0] a_X, a_Y;
  logic [9:0]  a_S;
  logic [3:0]  a_act;
  logic        a_hit, a_miss, a_launch;
  logic [1:0]  a_state;

  logic        b_start, b_pause, b_sv;
  logic [1:0]  b_si;
  logic [39:0] b_X, b_Y;
  logic [9:0]  b_S;
  logic [3:0]  b_act;
  logic        b_hit, b_miss, b_launch;
  logic [1:0]  b_state;

  fruit_spawn_ctrl dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .start(a_start), .pause(a_pause),
    .slice_valid(a_sv), .slice_idx(a_si), .FruitX(a_X), .FruitY(a_Y), .FruitS(a_S),
    .fruit_active(a_act), .hit_pulse(a_hit), .miss_pulse(a_miss),
    .launch_pulse(a_launch), .ctrl_state(a_state)
  );

  fruit_spawn_ctrl #(.SPAWN_PERIOD(2), .COUNTDOWN(4)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .start(b_start), .pause(b_pause),
    .slice_valid(b_sv), .slice_idx(b_si), .FruitX(b_X), .FruitY(b_Y), .FruitS(b_S),
    .fruit_active(b_act), .hit_pulse(b_hit), .miss_pulse(b_miss),
    .launch_pulse(b_launch), .ctrl_state(b_state)
  );

  typedef struct packed {
    int         frames;
    logic       pause;
    logic [1:0] st;
    logic       act;
    int         x;
    int         y;
    logic       launch;
    logic       miss;
  } vec_t;

  vec_t        tbl [0:11];
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] lf;
  int          exp_x2;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  initial begin
    a_start = 1'b0; a_pause = 1'b0; a_sv = 1'b0; a_si = 2'd0;
    b_start = 1'b0; b_pause = 1'b0; b_sv = 1'b0; b_si = 2'd0;
    Reset = 1'b1;
    #3;
    chk("rst_state", a_state, 0);
    chk("rst_active", a_act, 0);
    chk("rst_x", a_X[9:0], 0);
    chk("rst_y", a_Y[9:0], 0);
    chk("rst_size", a_S, 24);
    chk("rst_pulses", {a_hit, a_miss, a_launch}, 0);
    #9 Reset = 1'b0;

    // Second launch: LFSR stepped once at the first launch and 59 RUN frames after.
    lf = 16'hACE1;
    repeat (60) lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    exp_x2 = 64 + int'(lf[8:0]);

    // frames, pause, state, active, x, y, launch, miss (checked after the group)
    tbl[0]  = '{1,  1'b0, 2'd2, 1'b1, 290, 463, 1'b0, 1'b0};
    tbl[1]  = '{7,  1'b0, 2'd2, 1'b1, 297, 379, 1'b0, 1'b0};
    tbl[2]  = '{1,  1'b1, 2'd3, 1'b1, 297, 379, 1'b0, 1'b0};
    tbl[3]  = '{9,  1'b1, 2'd3, 1'b1, 297, 379, 1'b0, 1'b0};
    tbl[4]  = '{1,  1'b0, 2'd2, 1'b1, 297, 379, 1'b0, 1'b0};
    tbl[5]  = '{8,  1'b0, 2'd2, 1'b1, 305, 343, 1'b0, 1'b0};
    tbl[6]  = '{1,  1'b0, 2'd2, 1'b1, 306, 343, 1'b0, 1'b0};
    tbl[7]  = '{15, 1'b0, 2'd2, 1'b1, 321, 463, 1'b0, 1'b0};
    tbl[8]  = '{1,  1'b0, 2'd2, 1'b0, 0,   0,   1'b0, 1'b1};
    tbl[9]  = '{1,  1'b0, 2'd2, 1'b0, 0,   0,   1'b0, 1'b0};
    tbl[10] = '{25, 1'b0, 2'd2, 1'b0, 0,   0,   1'b0, 1'b0};
    tbl[11] = '{1,  1'b0, 2'd2, 1'b1, exp_x2, 479, 1'b1, 1'b0};

    // Countdown length and first launch on the default instance.
    a_start = 1'b1;
    tick(1);
    chk("a_cd_first", a_state, 1);
    a_start = 1'b0;
    tick(119);
    chk("a_cd_last", a_state, 1);
    tick(1);
    chk("a_run_state", a_state, 2);
    chk("a_run_nolaunch", a_launch, 0);
    tick(1);
    chk("a_launch1", a_launch, 1);
    chk("a_launch1_act", a_act, 1);
    chk("a_launch1_x", a_X[9:0], 289);
    chk("a_launch1_y", a_Y[9:0], 479);

    for (int r = 0; r < 12; r++) begin
      a_pause = tbl[r].pause;
      tick(tbl[r].frames);
      chk($sformatf("a_row%0d_state", r), a_state, tbl[r].st);
      chk($sformatf("a_row%0d_act", r), a_act, {3'b000, tbl[r].act});
      chk($sformatf("a_row%0d_launch", r), a_launch, tbl[r].launch);
      chk($sformatf("a_row%0d_miss", r), a_miss, tbl[r].miss);
      if (tbl[r].act) begin
        chk($sformatf("a_row%0d_x", r), a_X[9:0], tbl[r].x);
        chk($sformatf("a_row%0d_y", r), a_Y[9:0], tbl[r].y);
      end
    end

    // Fast-spawn instance: fill three slots, then reset mid-flight.
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    tick(4);
    chk("b_run_state", b_state, 2);
    tick(1);
    chk("b_first_x", b_X[9:0], 289);
    tick(4);
    chk("b_three_act", b_act, 4'b0111);
    chk("b_three_launch", b_launch, 1);
    Reset = 1'b1;
    #2;
    chk("b_rst_act", b_act, 0);
    chk("b_rst_state", b_state, 0);
    chk("b_rst_x", b_X, 0);
    chk("b_rst_y", b_Y, 0);
    chk("b_rst_launch", b_launch, 0);
    #1 Reset = 1'b0;

    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    tick(5);
    chk("b_relaunch_x", b_X[9:0], 289);
    chk("b_relaunch_launch", b_launch, 1);
    tick(8);
    chk("b_full_act", b_act, 4'hF);
    chk("b_full_dropped", b_launch, 0);
    tick(1);
    b_sv = 1'b1; b_si = 2'd2;
    tick(1);
    chk("b_slice2_hit", b_hit, 1);
    chk("b_slice2_nolaunch", b_launch, 0);
    chk("b_slice2_act", b_act, 4'b1011);
    b_sv = 1'b0;
    tick(1);
    chk("b_wait_launch", b_launch, 0);
    chk("b_wait_hit", b_hit, 0);
    tick(1);
    chk("b_slot2_launch", b_launch, 1);
    chk("b_slot2_act", b_act, 4'hF);
    chk("b_slot2_y", b_Y[29:20], 479);
    tick(21);
    chk("b_miss0_pulse", b_miss, 1);
    chk("b_miss0_act", b_act, 4'b1110);
    chk("b_miss0_hit", b_hit, 0);
    tick(1);
    chk("b_slot0_relaunch", b_launch, 1);
    b_sv = 1'b1; b_si = 2'd1;
    tick(1);
    chk("b_slicemiss_hit", b_hit, 1);
    chk("b_slicemiss_miss", b_miss, 0);
    chk("b_slicemiss_act", b_act, 4'b1101);
    tick(1);
    chk("b_inactive_hit", b_hit, 0);
    chk("b_inactive_launch", b_launch, 1);
    chk("b_inactive_act", b_act, 4'hF);
    b_sv = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
